// File: rtl/rr_mux_arbiter.sv
// N-channel valid/ready multiplexer with a built-in round-robin or fixed-priority arbiter
// driving the select, followed by a single registered output stage.
module rr_mux_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned MODE = 0,
  localparam int unsigned SW  = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  logic [W-1:0]  data_arr [N];
  logic [SW-1:0] ptr;
  logic [SW-1:0] start;
  logic [SW-1:0] win_idx;
  logic [SW:0]   idx_ext;
  logic [N-1:0]  grant;
  logic          found;
  logic          load;
  logic          transfer;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign data_arr[g] = in_data[g*W +: W];
  end

  // Search starts at the rr pointer (or at 0 for fixed priority) and wraps mod N.
  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx_ext = '0;
    start   = (MODE == 1) ? '0 : ptr;
    for (int unsigned k = 0; k < N; k++) begin
      idx_ext = {1'b0, start} + (SW+1)'(k);
      if (idx_ext >= (SW+1)'(N)) begin
        idx_ext = idx_ext - (SW+1)'(N);
      end
      if (!found && in_valid[idx_ext[SW-1:0]]) begin
        found   = 1'b1;
        win_idx = idx_ext[SW-1:0];
      end
    end
    if (found) begin
      grant[win_idx] = 1'b1;
    end
  end

  assign load     = ~out_valid | out_ready;
  assign transfer = load & found;
  assign in_ready = grant & {N{load & rst_n}};

  // Output stage and rr pointer; the pointer only moves when a word is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= data_arr[win_idx];
      out_sel   <= win_idx;
      ptr       <= (win_idx == SW'(N-1)) ? '0 : win_idx + SW'(1);
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: round-robin and fixed-priority instances share stimulus and are
// checked each cycle against a behavioural model, plus directed literal expectations.
module tb_rr_mux_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [W-1:0]   ch_data [N];
  logic [N*W-1:0] in_data;
  logic           out_ready;

  logic [N-1:0]   rr_in_ready, fp_in_ready;
  logic           rr_out_valid, fp_out_valid;
  logic [W-1:0]   rr_out_data, fp_out_data;
  logic [1:0]     rr_out_sel, fp_out_sel;

  int checks   = 0;
  int failures = 0;

  // model state, index 0 = round-robin, 1 = fixed priority
  logic       m_valid [2];
  logic [7:0] m_data  [2];
  int         m_sel   [2];
  int         m_ptr   [2];

  assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

  rr_mux_arbiter #(.N(N), .W(W), .MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
    .out_sel(rr_out_sel), .out_ready(out_ready));

  rr_mux_arbiter #(.N(N), .W(W), .MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_data(fp_out_data),
    .out_sel(fp_out_sel), .out_ready(out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // First requester found scanning from start (ptr in rr, 0 in fixed) with wrap; -1 if none.
  function automatic int winner(input int mode, input int ptr, input logic [N-1:0] v);
    int start;
    start = (mode == 1) ? 0 : ptr;
    for (int k = 0; k < N; k++) begin
      if (v[2'((start + k) % N)]) return (start + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_valid[m] = 1'b0; m_data[m] = 8'h00; m_sel[m] = 0; m_ptr[m] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        int w;
        w = winner(m, m_ptr[m], in_valid);
        if (!m_valid[m] || out_ready) begin
          if (w >= 0) begin
            m_valid[m] = 1'b1;
            m_data[m]  = ch_data[2'(w)];
            m_sel[m]   = w;
            m_ptr[m]   = (w + 1) % N;
          end else begin
            m_valid[m] = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic [N-1:0] exp_rdy;
      int w;
      exp_rdy = '0;
      w = winner(m, m_ptr[m], in_valid);
      if (rst_n && (!m_valid[m] || out_ready) && w >= 0) exp_rdy[2'(w)] = 1'b1;
      if (m == 0) begin
        check("rr_model_in_ready", 32'(rr_in_ready), 32'(exp_rdy));
        check("rr_model_out_valid", 32'(rr_out_valid), 32'(m_valid[0]));
        check("rr_model_out_data", 32'(rr_out_data), 32'(m_data[0]));
        check("rr_model_out_sel", 32'(rr_out_sel), 32'(m_sel[0]));
      end else begin
        check("fp_model_in_ready", 32'(fp_in_ready), 32'(exp_rdy));
        check("fp_model_out_valid", 32'(fp_out_valid), 32'(m_valid[1]));
        check("fp_model_out_data", 32'(fp_out_data), 32'(m_data[1]));
        check("fp_model_out_sel", 32'(fp_out_sel), 32'(m_sel[1]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) ch_data[i] = 8'(8'h30 + i);

    // reset with every channel requesting
    repeat (2) cyc();
    #1;
    check("reset_in_ready", 32'(rr_in_ready), 32'h0);
    check("reset_out_valid", 32'(rr_out_valid), 32'h0);
    check("reset_out_data", 32'(rr_out_data), 32'h0);
    check("reset_out_sel", 32'(rr_out_sel), 32'h0);
    check("reset_fp_in_ready", 32'(fp_in_ready), 32'h0);
    in_valid = 4'h0;
    cyc();
    rst_n = 1'b1;
    cyc();

    // single channel
    in_valid = 4'b0100;
    ch_data[2] = 8'hA5;
    #1;
    check("single_in_ready", 32'(rr_in_ready), 32'h4);
    cyc();
    check("single_out_valid", 32'(rr_out_valid), 32'h1);
    check("single_out_data", 32'(rr_out_data), 32'hA5);
    check("single_out_sel", 32'(rr_out_sel), 32'h2);
    in_valid = 4'h0;
    cyc();
    check("idle_out_valid", 32'(rr_out_valid), 32'h0);
    check("idle_out_data_hold", 32'(rr_out_data), 32'hA5);

    // round-robin fairness from ptr=0
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) ch_data[i] = 8'(8'h10 + i);
    in_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("rr_seq_sel", 32'(rr_out_sel), 32'(i % 4));
      check("rr_seq_data", 32'(rr_out_data), 32'(8'h10 + i % 4));
      check("fp_seq_sel", 32'(fp_out_sel), 32'h0);
    end

    // backpressure
    out_ready = 1'b0;
    #1;
    check("bp_in_ready", 32'(rr_in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("bp_in_ready_hold", 32'(rr_in_ready), 32'h0);
      check("bp_sel_hold", 32'(rr_out_sel), 32'h1);
      check("bp_data_hold", 32'(rr_out_data), 32'h11);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(rr_in_ready), 32'h4);
    cyc();
    check("bp_refill_valid", 32'(rr_out_valid), 32'h1);
    check("bp_refill_sel", 32'(rr_out_sel), 32'h2);
    check("bp_refill_data", 32'(rr_out_data), 32'h12);

    // fixed priority starvation
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("fp_prio_sel", 32'(fp_out_sel), 32'h1);
    end
    in_valid = 4'b1000;
    cyc();
    check("fp_drop_sel", 32'(fp_out_sel), 32'h3);
    check("fp_drop_data", 32'(fp_out_data), 32'h13);

    // wrap, then async reset mid-stream
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    in_valid = 4'b0100;
    cyc();
    check("wrap_pre_sel", 32'(rr_out_sel), 32'h2);
    in_valid = 4'b0011;
    cyc();
    check("wrap_sel0", 32'(rr_out_sel), 32'h0);
    cyc();
    check("wrap_sel1", 32'(rr_out_sel), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(rr_out_valid), 32'h0);
    check("async_rst_in_ready", 32'(rr_in_ready), 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    in_valid = 4'b1010;
    #1;
    check("post_rst_in_ready", 32'(rr_in_ready), 32'h2);
    cyc();
    check("post_rst_sel", 32'(rr_out_sel), 32'h1);

    in_valid = 4'h0;
    repeat (3) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
